cfg_epoch_scheduler: RTL and testbench

Sits between the UART-written configuration register bank and the GPS signal generator datapath (C/A code generator, Doppler NCO, noise/SNR mixer). Captures the bank outputs, waits until they are stable, then commits them to the datapath atomically. While the generator runs, commits happen only on a C/A code epoch. Sequences generator start and stop and issues the code-phase load pulse.

---
 rtl/cfg_epoch_scheduler.sv | 129 ++++++++++++
 tb/tb_cfg_epoch_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_epoch_scheduler.sv
// Configuration commit scheduler: snapshots the register bank, waits for it to settle,
// then commits it atomically to the generator datapath, aligned to C/A code epochs while running.
module cfg_epoch_scheduler #(
   parameter int SETTLE_CLKS   = 4096,
   parameter int EPOCH_TIMEOUT = 32768
) (
   input  logic        clk_in,
   input  logic        rst_in_n,
   input  logic        epoch_in,
   input  logic        enable_in,
   input  logic [4:0]  n_sat_in,
   input  logic        noise_off_in,
   input  logic        signal_off_in,
   input  logic [15:0] ca_phase_in,
   input  logic [7:0]  doppler_in,
   input  logic [7:0]  snr_in,
   output logic [4:0]  n_sat_out,
   output logic        noise_off_out,
   output logic        signal_off_out,
   output logic [15:0] ca_phase_out,
   output logic [7:0]  doppler_out,
   output logic [7:0]  snr_out,
   output logic        gen_run_out,
   output logic        load_out,
   output logic        pending_out,
   output logic        timeout_out
);

   localparam int CW = $clog2(SETTLE_CLKS + 1);
   localparam int TW = $clog2(EPOCH_TIMEOUT);
   localparam logic [CW-1:0] SETTLE_MAX   = CW'(SETTLE_CLKS);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(EPOCH_TIMEOUT - 1);
   // Field order: enable, n_sat, noise_off, signal_off, ca_phase, doppler, snr.
   localparam logic [39:0] RESET_SET = {1'b0, 5'd0, 1'b0, 1'b0, 16'd0, 8'hC0, 8'h00};

   typedef enum logic [1:0] {STOPPED, LOAD, RUN, WAIT_EPOCH} state_t;

   state_t        state, state_nxt;
   logic [39:0]   bank, snap, comm;
   logic [CW-1:0] settle_cnt;
   logic [TW-1:0] timer;
   logic          mismatch, stable, pending, snap_en;
   logic          commit, run_nxt, forced;

   assign bank     = {enable_in, n_sat_in, noise_off_in, signal_off_in,
                      ca_phase_in, doppler_in, snr_in};
   assign mismatch = (bank != snap);
   assign stable   = (settle_cnt == SETTLE_MAX) && !mismatch;
   assign pending  = (snap != comm);
   assign snap_en  = snap[39];

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         snap       <= RESET_SET;
         settle_cnt <= '0;
      end else if (mismatch) begin
         snap       <= bank;
         settle_cnt <= '0;
      end else if (settle_cnt != SETTLE_MAX) begin
         settle_cnt <= settle_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      run_nxt   = gen_run_out;
      forced    = 1'b0;
      case (state)
         STOPPED: begin
            if (stable && pending) begin
               commit = 1'b1;
               if (snap_en) state_nxt = LOAD;
            end
         end
         LOAD: begin
            state_nxt = RUN;
            run_nxt   = 1'b1;
         end
         RUN: begin
            if (stable && pending) state_nxt = WAIT_EPOCH;
         end
         WAIT_EPOCH: begin
            // A bank write racing the epoch aborts the commit; the new value must resettle.
            if (mismatch) begin
               state_nxt = RUN;
            end else if (epoch_in || (timer == TIMEOUT_LAST)) begin
               commit = 1'b1;
               forced = !epoch_in;
               if (snap_en) begin
                  state_nxt = LOAD;
               end else begin
                  state_nxt = STOPPED;
                  run_nxt   = 1'b0;
               end
            end
         end
         default: state_nxt = STOPPED;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in_n) begin
      if (!rst_in_n) begin
         state       <= STOPPED;
         comm        <= RESET_SET;
         gen_run_out <= 1'b0;
         timeout_out <= 1'b0;
         pending_out <= 1'b0;
         timer       <= '0;
      end else begin
         state       <= state_nxt;
         gen_run_out <= run_nxt;
         pending_out <= pending;
         if (commit) comm <= snap;
         if (forced) timeout_out <= 1'b1;
         if (state == WAIT_EPOCH) timer <= timer + 1'b1;
         else                     timer <= '0;
      end
   end

   assign load_out       = (state == LOAD);
   assign n_sat_out      = comm[38:34];
   assign noise_off_out  = comm[33];
   assign signal_off_out = comm[32];
   assign ca_phase_out   = comm[31:16];
   assign doppler_out    = comm[15:8];
   assign snr_out        = comm[7:0];

endmodule

// File: tb/tb_cfg_epoch_scheduler.sv
// Directed bench for cfg_epoch_scheduler: stimulus pushes expected output events,
// a negedge monitor pops and compares every observed commit/load/reset event.
module tb_cfg_epoch_scheduler;

   localparam int S = 4096;
   localparam int T = 32768;

   logic        clk_in = 1'b0;
   logic        rst_in_n;
   logic        epoch_in, enable_in, noise_off_in, signal_off_in;
   logic [4:0]  n_sat_in;
   logic [15:0] ca_phase_in;
   logic [7:0]  doppler_in, snr_in;
   logic [4:0]  n_sat_out;
   logic        noise_off_out, signal_off_out;
   logic [15:0] ca_phase_out;
   logic [7:0]  doppler_out, snr_out;
   logic        gen_run_out, load_out, pending_out, timeout_out;

   int compared   = 0;
   int mismatched = 0;
   logic [31:0] cyc = 0;
   // Event word: {cycle stamp, load_out, committed fields}.
   logic [71:0] exp_q[$];

   cfg_epoch_scheduler #(.SETTLE_CLKS(S), .EPOCH_TIMEOUT(T)) dut (
      .clk_in(clk_in), .rst_in_n(rst_in_n), .epoch_in(epoch_in),
      .enable_in(enable_in), .n_sat_in(n_sat_in), .noise_off_in(noise_off_in),
      .signal_off_in(signal_off_in), .ca_phase_in(ca_phase_in),
      .doppler_in(doppler_in), .snr_in(snr_in),
      .n_sat_out(n_sat_out), .noise_off_out(noise_off_out),
      .signal_off_out(signal_off_out), .ca_phase_out(ca_phase_out),
      .doppler_out(doppler_out), .snr_out(snr_out),
      .gen_run_out(gen_run_out), .load_out(load_out),
      .pending_out(pending_out), .timeout_out(timeout_out)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   // ---------------- helpers ----------------
   function automatic logic [38:0] fset(logic [4:0] ns, logic no, logic so,
                                        logic [15:0] ca, logic [7:0] dp, logic [7:0] sn);
      return {ns, no, so, ca, dp, sn};
   endfunction

   function automatic logic [71:0] ev(logic [31:0] c, logic ld, logic [38:0] f);
      return {c, ld, f};
   endfunction

   task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic pulse_epoch();
      epoch_in = 1'b1;
      step(1);
      epoch_in = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [38:0] prev_f = fset(5'd0, 1'b0, 1'b0, 16'h0000, 8'hC0, 8'h00);
   logic        prev_load = 1'b0;

   always @(negedge clk_in) begin
      logic [38:0] cur_f;
      logic [71:0] e;
      cur_f = {n_sat_out, noise_off_out, signal_off_out, ca_phase_out, doppler_out, snr_out};
      if (load_out === 1'b1) begin
         compared++;
         if (prev_load === 1'b1) begin
            mismatched++;
            $display("FAIL load_double: load_out high two cycles in a row at cycle %0d", cyc);
         end
      end
      if (load_out !== 1'b0 || cur_f !== prev_f) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_event: got %0h with nothing expected (cycle %0d)",
                     ev(cyc, load_out, cur_f), cyc);
         end else begin
            e = exp_q.pop_front();
            chk("output_event", ev(cyc, load_out, cur_f), e);
         end
      end
      prev_f    = cur_f;
      prev_load = load_out;
   end

   // ---------------- stimulus ----------------
   logic [31:0] t0;

   initial begin
      epoch_in = 0; enable_in = 0; n_sat_in = 0; noise_off_in = 0; signal_off_in = 0;
      ca_phase_in = 16'h0000; doppler_in = 8'hC0; snr_in = 8'h00;
      rst_in_n = 1'b1;
      #1 rst_in_n = 1'b0;
      step(3);
      rst_in_n = 1'b1;

      // Reset state
      chk("rst_doppler", 72'(doppler_out), 72'hC0);
      chk("rst_gen_run", 72'(gen_run_out), 72'h0);
      chk("rst_load",    72'(load_out),    72'h0);
      chk("rst_timeout", 72'(timeout_out), 72'h0);
      chk("rst_pending", 72'(pending_out), 72'h0);
      step(10000);
      chk("idle_doppler", 72'(doppler_out), 72'hC0);
      chk("idle_gen_run", 72'(gen_run_out), 72'h0);

      // Start: load exactly S+2 cycles after the input change
      t0 = cyc;
      enable_in = 1; ca_phase_in = 16'h0123; doppler_in = 8'hD0;
      exp_q.push_back(ev(t0 + S + 2, 1'b1, fset(0, 0, 0, 16'h0123, 8'hD0, 8'h00)));
      step(S + 1);
      chk("start_no_early_load", 72'(load_out), 72'h0);
      step(1);
      chk("start_load",     72'(load_out),     72'h1);
      chk("start_ca_phase", 72'(ca_phase_out), 72'h0123);
      step(1);
      chk("start_gen_run",  72'(gen_run_out),  72'h1);
      chk("start_load_end", 72'(load_out),     72'h0);
      step(20);

      // Split write: lo byte, hi byte 2840 later, epoch 6000 after hi
      t0 = cyc;
      ca_phase_in = 16'h0145;
      step(100);
      chk("split_pending", 72'(pending_out), 72'h1);
      step(2740);
      ca_phase_in = 16'h6745;
      step(6000);
      exp_q.push_back(ev(t0 + 2840 + 6000 + 1, 1'b1, fset(0, 0, 0, 16'h6745, 8'hD0, 8'h00)));
      chk("split_hold_ca", 72'(ca_phase_out), 72'h0123);
      pulse_epoch();
      chk("split_load", 72'(load_out),     72'h1);
      chk("split_ca",   72'(ca_phase_out), 72'h6745);
      step(3);
      chk("split_pending_clear", 72'(pending_out), 72'h0);

      // Change on the same cycle as epoch: abort, commit on the next epoch after resettling
      t0 = cyc;
      snr_in = 8'h11;
      step(4200);
      snr_in = 8'h22;
      pulse_epoch();
      chk("race_no_load", 72'(load_out), 72'h0);
      chk("race_snr",     72'(snr_out),  72'h00);
      step(4199);
      exp_q.push_back(ev(t0 + 8401, 1'b1, fset(0, 0, 0, 16'h6745, 8'hD0, 8'h22)));
      pulse_epoch();
      chk("race_commit_snr", 72'(snr_out), 72'h22);
      step(20);

      // Forced commit after T cycles in WAIT_EPOCH
      t0 = cyc;
      snr_in = 8'h40;
      exp_q.push_back(ev(t0 + S + 2 + T, 1'b1, fset(0, 0, 0, 16'h6745, 8'hD0, 8'h40)));
      step(S + 1 + T);
      chk("to_not_yet",      72'(timeout_out), 72'h0);
      chk("to_snr_held",     72'(snr_out),     72'h22);
      step(1);
      chk("to_load",         72'(load_out),    72'h1);
      chk("to_snr",          72'(snr_out),     72'h40);
      chk("to_flag",         72'(timeout_out), 72'h1);
      step(20);

      // Disable via epoch: commit without load, gen_run drops the next cycle
      t0 = cyc;
      enable_in = 0; doppler_in = 8'hE0;
      step(4200);
      chk("stop_run_before", 72'(gen_run_out), 72'h1);
      exp_q.push_back(ev(t0 + 4201, 1'b0, fset(0, 0, 0, 16'h6745, 8'hE0, 8'h40)));
      pulse_epoch();
      chk("stop_gen_run", 72'(gen_run_out), 72'h0);
      chk("stop_no_load", 72'(load_out),    72'h0);
      chk("stop_timeout_sticky", 72'(timeout_out), 72'h1);
      step(20);

      // Restart from STOPPED, then reset in the middle of WAIT_EPOCH
      t0 = cyc;
      enable_in = 1;
      exp_q.push_back(ev(t0 + S + 2, 1'b1, fset(0, 0, 0, 16'h6745, 8'hE0, 8'h40)));
      step(S + 10);
      chk("restart_gen_run", 72'(gen_run_out), 72'h1);
      t0 = cyc;
      doppler_in = 8'h55;
      step(4200);
      exp_q.push_back(ev(t0 + 4200, 1'b0, fset(0, 0, 0, 16'h0000, 8'hC0, 8'h00)));
      rst_in_n = 1'b0;
      #1;
      chk("mid_rst_gen_run", 72'(gen_run_out),  72'h0);
      chk("mid_rst_load",    72'(load_out),     72'h0);
      chk("mid_rst_timeout", 72'(timeout_out),  72'h0);
      chk("mid_rst_doppler", 72'(doppler_out),  72'hC0);
      chk("mid_rst_ca",      72'(ca_phase_out), 72'h0);
      enable_in = 0; ca_phase_in = 16'h0000; doppler_in = 8'hC0; snr_in = 8'h00;
      step(3);
      rst_in_n = 1'b1;
      step(5000);
      chk("post_rst_gen_run", 72'(gen_run_out), 72'h0);
      chk("events_drained", 72'(exp_q.size()), 72'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
